// File: rtl/register_bank.sv
// Parametrised register bank: NUM_REGS loadable registers, an incrementable index register,
// and an output FIFO drained by a valid/ready handshake.

module reg_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [WIDTH-1:0] wdata,
  input  logic             inc,
  output logic [WIDTH-1:0] q,
  output logic             wrap
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q    <= '0;
      wrap <= 1'b0;
    end else begin
      wrap <= inc && (&q);
      if (we)       q <= wdata;
      else if (inc) q <= q + 1'b1;
    end
  end
endmodule

module register_bank #(
  parameter int WIDTH     = 8,
  parameter int NUM_REGS  = 4,
  parameter int SEL_BITS  = 2,
  parameter int X_INDEX   = 2,
  parameter int OUT_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          load,
  input  logic [SEL_BITS-1:0]           load_sel,
  input  logic [WIDTH-1:0]              dbus,
  input  logic                          inc_x,
  input  logic                          do_out,
  input  logic [SEL_BITS-1:0]           rd_sel,
  output logic [WIDTH-1:0]              rd_data,
  output logic [NUM_REGS*WIDTH-1:0]     regs_flat,
  output logic                          x_wrap,
  output logic [WIDTH-1:0]              out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(OUT_DEPTH):0]    out_count,
  output logic                          out_overflow
);
  localparam int PW = $clog2(OUT_DEPTH);
  localparam int CW = PW + 1;

  logic [NUM_REGS-1:0][WIDTH-1:0] regs;
  logic [NUM_REGS-1:0]            wrap_v;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    logic we, inc;
    assign we  = load && (load_sel == SEL_BITS'(i));
    // a same-cycle load of X takes priority over the increment
    assign inc = (i == X_INDEX) && inc_x && !we;
    reg_slot #(.WIDTH(WIDTH)) u_slot (
      .clk(clk), .reset(reset), .we(we), .wdata(dbus), .inc(inc),
      .q(regs[i]), .wrap(wrap_v[i])
    );
  end

  // only the X slot ever has inc asserted, so the OR is just its strobe
  assign x_wrap    = |wrap_v;
  assign regs_flat = regs;

  always_comb begin
    rd_data = '0;
    if (32'(rd_sel) < NUM_REGS) rd_data = regs[rd_sel];
  end

  logic [OUT_DEPTH-1:0][WIDTH-1:0] mem;
  logic [PW-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [CW-1:0] count;
  logic          full, pop, push, head_is_new;

  assign rd_nxt    = rd_ptr + 1'b1;
  assign full      = (count == CW'(OUT_DEPTH));
  assign out_valid = (count != '0);
  assign out_count = count;
  assign pop       = out_valid && out_ready;
  assign push      = do_out && (!full || pop);
  // pushed word becomes the head when nothing older remains after this edge
  assign head_is_new = (count == '0) || (pop && count == CW'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem          <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      out_data     <= '0;
      out_overflow <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= dbus;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_nxt;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (do_out && full && !pop) out_overflow <= 1'b1;
      // registered head; holds its last value once the FIFO drains
      if (push && head_is_new)         out_data <= dbus;
      else if (pop && count > CW'(1))  out_data <= mem[rd_nxt];
    end
  end
endmodule

// File: tb/tb_register_bank.sv
// Directed scenarios plus randomized traffic against a queue/array reference model.

module tb_register_bank;
  localparam int W = 8, N = 4, SB = 2, XI = 2, D = 4, CW = 3;

  logic clk = 1'b0;
  logic reset, load, inc_x, do_out, out_ready;
  logic [SB-1:0] load_sel, rd_sel;
  logic [W-1:0] dbus, rd_data, out_data;
  logic [N*W-1:0] regs_flat;
  logic x_wrap, out_valid, out_overflow;
  logic [CW-1:0] out_count;

  register_bank #(.WIDTH(W), .NUM_REGS(N), .SEL_BITS(SB), .X_INDEX(XI), .OUT_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .load(load), .load_sel(load_sel), .dbus(dbus),
    .inc_x(inc_x), .do_out(do_out), .rd_sel(rd_sel), .rd_data(rd_data),
    .regs_flat(regs_flat), .x_wrap(x_wrap), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_count(out_count), .out_overflow(out_overflow)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // reference model
  int m_reg[N];
  logic [W-1:0] mq[$];
  logic [W-1:0] m_last;
  bit m_wrap, m_ovf;

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_reg[i] = 0;
    mq.delete();
    m_last = '0; m_wrap = 0; m_ovf = 0;
  endtask

  task automatic model_edge();
    bit pop, full;
    if (reset) begin model_reset(); return; end
    pop  = (mq.size() > 0) && out_ready;
    full = (mq.size() == D);
    m_wrap = 0;
    if (inc_x && !(load && int'(load_sel) == XI)) begin
      if (m_reg[XI] == (1 << W) - 1) m_wrap = 1;
      m_reg[XI] = (m_reg[XI] + 1) % (1 << W);
    end
    if (load && int'(load_sel) < N) m_reg[load_sel] = int'(dbus);
    if (pop) void'(mq.pop_front());
    if (do_out) begin
      if (!full || pop) mq.push_back(dbus);
      else m_ovf = 1;
    end
    if (mq.size() > 0) m_last = mq[0];
  endtask

  task automatic idle();
    load = 0; inc_x = 0; do_out = 0; out_ready = 0;
    load_sel = '0; dbus = '0; rd_sel = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    tick(); tick();
    reset = 0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    #1;
    checks++; if (regs_flat !== '0) begin errors++; $display("FAIL reset_regs got %h want 0", regs_flat); end
    checks++; if (out_count !== '0 || out_valid !== 1'b0) begin errors++; $display("FAIL reset_fifo got cnt=%0d vld=%b want 0/0", out_count, out_valid); end
    checks++; if (out_data !== '0 || x_wrap !== 1'b0 || out_overflow !== 1'b0) begin errors++; $display("FAIL reset_flags got data=%h wrap=%b ovf=%b want 0", out_data, x_wrap, out_overflow); end
    tick();
    reset = 0;
    model_reset();
  endtask

  task automatic test_load();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      load = 1; load_sel = SB'(i); dbus = W'(8'h11 * (i + 1));
      tick();
    end
    idle();
    rd_sel = 2'd2;
    #1;
    checks++; if (regs_flat !== 32'h44332211) begin errors++; $display("FAIL load_flat got %h want 44332211", regs_flat); end
    checks++; if (rd_data !== 8'h33) begin errors++; $display("FAIL load_rd got %h want 33", rd_data); end
  endtask

  task automatic test_wrap();
    do_reset();
    load = 1; load_sel = SB'(XI); dbus = 8'hFE;
    tick();
    idle(); inc_x = 1;
    tick();
    checks++; if (regs_flat[XI*W +: W] !== 8'hFF || x_wrap !== 1'b0) begin errors++; $display("FAIL wrap_ff got x=%h wrap=%b want ff/0", regs_flat[XI*W +: W], x_wrap); end
    tick();
    inc_x = 0;
    checks++; if (regs_flat[XI*W +: W] !== 8'h00 || x_wrap !== 1'b1) begin errors++; $display("FAIL wrap_00 got x=%h wrap=%b want 00/1", regs_flat[XI*W +: W], x_wrap); end
    tick();
    checks++; if (x_wrap !== 1'b0) begin errors++; $display("FAIL wrap_pulse got %b want 0", x_wrap); end
  endtask

  task automatic test_load_beats_inc();
    do_reset();
    load = 1; load_sel = SB'(XI); dbus = 8'h80; inc_x = 1;
    tick();
    checks++; if (regs_flat[XI*W +: W] !== 8'h80 || x_wrap !== 1'b0) begin errors++; $display("FAIL load_win got x=%h wrap=%b want 80/0", regs_flat[XI*W +: W], x_wrap); end
    load_sel = 2'd0; dbus = 8'h05;
    tick();
    idle();
    checks++; if (regs_flat[XI*W +: W] !== 8'h81 || regs_flat[7:0] !== 8'h05) begin errors++; $display("FAIL load_inc_both got x=%h r0=%h want 81/05", regs_flat[XI*W +: W], regs_flat[7:0]); end
  endtask

  task automatic test_fill_overflow();
    logic [W-1:0] v;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      do_out = 1; dbus = W'(8'hA0 + i);
      tick();
      if (i == 0) begin
        checks++; if (out_valid !== 1'b1 || out_data !== 8'hA0) begin errors++; $display("FAIL first_push got vld=%b data=%h want 1/a0", out_valid, out_data); end
      end
    end
    do_out = 0;
    checks++; if (out_count !== 3'd4 || out_overflow !== 1'b1 || out_data !== 8'hA0) begin errors++; $display("FAIL fill got cnt=%0d ovf=%b data=%h want 4/1/a0", out_count, out_overflow, out_data); end
    out_ready = 1;
    for (int k = 0; k < 4; k++) begin
      v = W'(8'hA0 + k);
      checks++; if (out_valid !== 1'b1 || out_data !== v) begin errors++; $display("FAIL drain%0d got vld=%b data=%h want 1/%h", k, out_valid, out_data, v); end
      tick();
    end
    checks++; if (out_valid !== 1'b0 || out_count !== '0 || out_data !== 8'hA3) begin errors++; $display("FAIL drained got vld=%b cnt=%0d data=%h want 0/0/a3", out_valid, out_count, out_data); end
    tick();
    idle();
  endtask

  task automatic test_push_pop_full();
    logic [W-1:0] exp[4];
    exp[0] = 8'hB1; exp[1] = 8'hB2; exp[2] = 8'hB3; exp[3] = 8'h55;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      do_out = 1; dbus = W'(8'hB0 + i);
      tick();
    end
    dbus = 8'h55; out_ready = 1;
    tick();
    do_out = 0;
    checks++; if (out_count !== 3'd4 || out_overflow !== 1'b0) begin errors++; $display("FAIL full_pp got cnt=%0d ovf=%b want 4/0", out_count, out_overflow); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== exp[k]) begin errors++; $display("FAIL full_pp_drain%0d got %h want %h", k, out_data, exp[k]); end
      tick();
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_pp_empty got %b want 0", out_valid); end
    idle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      do_out = 1; dbus = W'(8'hC0 + i);
      tick();
    end
    do_out = 0; out_ready = 1;
    tick();
    out_ready = 0; load = 1; load_sel = SB'(XI); dbus = 8'h7F;
    tick();
    idle();
    checks++; if (out_count !== 3'd3 || regs_flat[XI*W +: W] !== 8'h7F || out_overflow !== 1'b1) begin errors++; $display("FAIL pre_reset got cnt=%0d x=%h ovf=%b want 3/7f/1", out_count, regs_flat[XI*W +: W], out_overflow); end
    #2;
    reset = 1;
    model_reset();
    #1;
    checks++; if (regs_flat !== '0 || out_data !== '0) begin errors++; $display("FAIL mid_reset got regs=%h data=%h want 0", regs_flat, out_data); end
    checks++; if (out_valid !== 1'b0 || out_count !== '0 || out_overflow !== 1'b0) begin errors++; $display("FAIL mid_reset_fifo got vld=%b cnt=%0d ovf=%b want 0", out_valid, out_count, out_overflow); end
    tick();
    reset = 0;
  endtask

  task automatic test_random();
    logic [N*W-1:0] ef;
    int ec;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if (c == 300) do_reset();
      load      = ($urandom_range(0, 3) == 0);
      load_sel  = SB'($urandom_range(0, 3));
      dbus      = ($urandom_range(0, 3) == 0) ? 8'hFE : W'($urandom);
      inc_x     = $urandom_range(0, 1) == 1;
      do_out    = ($urandom_range(0, 9) < 4);
      out_ready = ($urandom_range(0, 9) < 4);
      rd_sel    = SB'($urandom_range(0, 3));
      #1;
      checks++; if (rd_data !== W'(m_reg[rd_sel])) begin errors++; $display("FAIL rnd_rd c=%0d got %h want %h", c, rd_data, W'(m_reg[rd_sel])); end
      tick();
      for (int i = 0; i < N; i++) ef[i*W +: W] = W'(m_reg[i]);
      ec = mq.size();
      checks++; if (regs_flat !== ef || x_wrap !== m_wrap) begin errors++; $display("FAIL rnd_regs c=%0d got %h/%b want %h/%b", c, regs_flat, x_wrap, ef, m_wrap); end
      checks++; if (out_count !== CW'(ec) || out_valid !== (ec > 0) || out_overflow !== m_ovf) begin errors++; $display("FAIL rnd_fifo c=%0d got cnt=%0d vld=%b ovf=%b want %0d/%b/%b", c, out_count, out_valid, out_overflow, ec, ec > 0, m_ovf); end
      checks++; if (out_data !== m_last) begin errors++; $display("FAIL rnd_data c=%0d got %h want %h", c, out_data, m_last); end
    end
    idle();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_load();
    test_wrap();
    test_load_beats_inc();
    test_fill_overflow();
    test_push_pop_full();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/register_bank.md
Name: register_bank

Overview:
- Parametrised successor to the fixed four-register A/B/X/Q bank.
- Holds NUM_REGS general registers of WIDTH bits, each loaded from the data bus under a per-cycle select.
- The index register X supports in-place increment, with a wrap strobe.
- The output register becomes an OUT_DEPTH-entry FIFO drained by a valid/ready handshake, so a slow display or peripheral no longer loses values written by back-to-back OUT instructions.
- Sits between the control decoder and the data bus, beside the ALU.

Parameters:
- WIDTH, 8: data bus and register width in bits.
- NUM_REGS, 4: number of general registers; must be at least 2.
- SEL_BITS, 2: width of the register select; 2^SEL_BITS >= NUM_REGS.
- X_INDEX, 2: index of the register that responds to inc_x.
- OUT_DEPTH, 4: output FIFO depth; power of two, at least 2.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- load  in  1  write dbus into register load_sel this cycle.
- load_sel  in  SEL_BITS  target register for load.
- dbus  in  WIDTH  data bus.
- inc_x  in  1  increment register X_INDEX by 1.
- do_out  in  1  push dbus into the output FIFO.
- rd_sel  in  SEL_BITS  combinational read select.
- rd_data  out  WIDTH  contents of register rd_sel.
- regs_flat  out  NUM_REGS*WIDTH  all registers; register i occupies bits [i*WIDTH +: WIDTH].
- x_wrap  out  1  one-cycle pulse when an increment wraps.
- out_data  out  WIDTH  FIFO head.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts the head.
- out_count  out  $clog2(OUT_DEPTH)+1  current FIFO occupancy.
- out_overflow  out  1  sticky: a push was dropped.

Behaviour:
- Reset (asynchronous assert, takes effect immediately; release synchronous to clk):
  - All registers = 0.
  - FIFO empty: out_count = 0, out_valid = 0, out_data = 0.
  - x_wrap = 0, out_overflow = 0.
  - Reset asserted mid-transfer discards FIFO contents and pending pops without error.
- Load:
  - On the edge with load = 1, register[load_sel] takes dbus.
  - Visible on regs_flat and rd_data one cycle later.
  - load_sel >= NUM_REGS: write ignored, no state change.
- Increment:
  - On the edge with inc_x = 1, register[X_INDEX] takes its value + 1, modulo 2^WIDTH.
  - At all-ones it becomes 0 and x_wrap pulses high for exactly the following cycle.
- Load and increment together:
  - If load and inc_x target the same register in one cycle, load wins; no increment and no x_wrap.
  - If they target different registers, both take effect.
- Read: rd_data = register[rd_sel], purely combinational; 0 when rd_sel >= NUM_REGS.
- Output FIFO:
  - Push: do_out = 1 writes dbus at the tail on the clock edge.
  - Pop: out_valid && out_ready advances the head on the clock edge.
  - No fall-through: a value pushed into an empty FIFO appears with out_valid = 1 on the cycle after the push.
  - out_data is held stable while out_valid = 1 and out_ready = 0.
  - When empty, out_data holds its last value (0 after reset); consumers qualify it with out_valid.
- Push and pop in the same cycle:
  - Both occur; out_count is unchanged.
  - This also applies when full: the push is accepted because the pop frees a slot.
- Full (out_count = OUT_DEPTH) with do_out = 1 and no pop:
  - The push is dropped and the FIFO is unchanged.
  - out_overflow sets and stays set until reset.
- Empty with out_ready = 1: no pop and no change.
- Pointers are $clog2(OUT_DEPTH) bits and wrap naturally.
- out_count increments on push-only, decrements on pop-only, and never exceeds OUT_DEPTH.
- load, inc_x and do_out are independent and may all be active in one cycle.

Test Plan:
- Load: after reset, load with sel = 0, 1, 2, 3 and dbus = 0x11, 0x22, 0x33, 0x44 on successive cycles -> regs_flat = 0x44332211; rd_sel = 2 gives rd_data = 0x33.
- Wrap: load X with 0xFE, then inc_x for 2 cycles -> X = 0xFF then 0x00; x_wrap pulses once, in the cycle after the second increment.
- Load beats increment: load with sel = X_INDEX, dbus = 0x80, inc_x = 1 in the same cycle -> X = 0x80, x_wrap = 0.
- Fill and overflow: out_ready = 0, push 0xA0, 0xA1, 0xA2, 0xA3, 0xA4 -> out_count = 4, out_overflow = 1, out_data = 0xA0; then out_ready = 1 -> drains 0xA0..0xA3 in order, 0xA4 absent, out_valid drops after 4 pops.
- Push and pop when full: FIFO full, do_out with dbus = 0x55 and out_ready = 1 in one cycle -> out_count stays 4, no overflow, 0x55 emerges last.
- Reset mid-operation: FIFO holds 3 entries and X = 0x7F; assert reset mid-cycle -> all outputs 0 immediately, out_valid = 0, out_overflow = 0.
